// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 cipher stages.
`default_nettype none

package rc4_pkg;

    localparam int BYTE_W = 8;
    localparam int S_SIZE = 256;

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        LEN    = 4'd1,
        PT0    = 4'd2,
        RD_SI  = 4'd3,
        RD_SJ  = 4'd4,
        WR_SI  = 4'd5,
        WR_SJ  = 4'd6,
        RD_PAD = 4'd7,
        XOR    = 4'd8
    } state_t;

endpackage

`default_nettype wire

// File: rtl/rc4_prga.sv
// RC4 keystream stage: walks and swaps S, XORs the keystream with ciphertext
// and writes the length-prefixed plaintext message.
`default_nettype none

module rc4_prga
    import rc4_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    output logic              rdy,
    output logic [BYTE_W-1:0] s_addr,
    output logic [BYTE_W-1:0] s_din,
    input  logic [BYTE_W-1:0] s_dout,
    output logic              s_wren,
    output logic [BYTE_W-1:0] ct_addr,
    input  logic [BYTE_W-1:0] ct_dout,
    output logic [BYTE_W-1:0] pt_addr,
    output logic [BYTE_W-1:0] pt_din,
    output logic              pt_wren
);

    state_t            state_q;
    logic [BYTE_W-1:0] i_q, j_q, k_q, len_q, si_q, sj_q;
    logic [BYTE_W-1:0] i_d, j_d;

    // j_d is only meaningful in RD_SJ, where s_dout carries S[i].
    assign i_d = i_q + 8'd1;
    assign j_d = j_q + s_dout;
    assign rdy = (state_q == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            len_q   <= '0;
            si_q    <= '0;
            sj_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (en) begin
                        i_q     <= '0;
                        j_q     <= '0;
                        k_q     <= 8'd1;
                        state_q <= LEN;
                    end
                end
                LEN: state_q <= PT0;
                PT0: begin
                    len_q   <= ct_dout;
                    state_q <= (ct_dout == '0) ? IDLE : RD_SI;
                end
                RD_SI: begin
                    i_q     <= i_d;
                    state_q <= RD_SJ;
                end
                RD_SJ: begin
                    si_q    <= s_dout;
                    j_q     <= j_d;
                    state_q <= WR_SI;
                end
                WR_SI: begin
                    sj_q    <= s_dout;
                    state_q <= WR_SJ;
                end
                WR_SJ:  state_q <= RD_PAD;
                RD_PAD: state_q <= XOR;
                XOR: begin
                    // Compare before incrementing so L=255 ends without k wrapping.
                    if (k_q == len_q) begin
                        state_q <= IDLE;
                    end else begin
                        k_q     <= k_q + 8'd1;
                        state_q <= RD_SI;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        s_addr  = '0;
        s_din   = '0;
        s_wren  = 1'b0;
        ct_addr = '0;
        pt_addr = '0;
        pt_din  = '0;
        pt_wren = 1'b0;
        case (state_q)
            PT0: begin
                pt_addr = '0;
                pt_din  = ct_dout;
                pt_wren = 1'b1;
            end
            RD_SI: s_addr = i_d;
            RD_SJ: s_addr = j_d;
            WR_SI: begin
                s_addr = i_q;
                s_din  = s_dout;
                s_wren = 1'b1;
            end
            WR_SJ: begin
                s_addr = j_q;
                s_din  = si_q;
                s_wren = 1'b1;
            end
            RD_PAD: begin
                s_addr  = si_q + sj_q;
                ct_addr = k_q;
            end
            XOR: begin
                pt_addr = k_q;
                pt_din  = s_dout ^ ct_dout;
                pt_wren = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: doc/rc4_prga.md
Name: rc4_prga

Overview:
- Keystream generation stage of the RC4 cipher pipeline. It is the reader of the S-box state that the KSA stage writes.
- Once started, it walks S in status RAM using the RC4 pseudo-random generation algorithm (PRGA), swapping entries as it goes.
- Each keystream byte is XORed with a ciphertext byte from the ciphertext ROM, and the result is written to the plaintext RAM.
- It uses the same rdy/en start handshake as the other cipher stages, so the top-level sequencer adds it as the state after KSA_RUNNING.

Parameters:
- None. All widths are fixed at 8 bits by the RC4 byte algorithm. S size is 256.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  start request; honoured only while rdy=1
- rdy  out  1  high when idle and able to accept en
- s_addr  out  8  status (S) RAM address
- s_din  out  8  S RAM write data
- s_dout  in  8  S RAM read data, 1-cycle read latency
- s_wren  out  1  S RAM write enable
- ct_addr  out  8  ciphertext ROM address
- ct_dout  in  8  ciphertext ROM data, 1-cycle read latency
- pt_addr  out  8  plaintext RAM address
- pt_din  out  8  plaintext RAM write data
- pt_wren  out  1  plaintext RAM write enable

Behaviour:
- Clock and reset: one clock domain, clk. Reset is asynchronous and active-low on rst_n.
- Reset values:
  - state=IDLE; i, j, k, len, si, sj all 0.
  - rdy=1.
  - All wren outputs 0; all address and data outputs 0.
- Memory timing: for every memory, the address is driven in cycle t and the data is sampled in cycle t+1.
- Message format: ct[0] holds the message length L (0..255); ct[1..L] hold the ciphertext. The block writes pt[0]=L and pt[1..L] with the plaintext.
- Handshake:
  - rdy = (state==IDLE), combinational.
  - en sampled high with rdy high starts a run; rdy is low from the next cycle.
  - en while busy is ignored.
  - On completion the block returns to IDLE with no extra handshake.
- States and transitions:
  - IDLE: on en, clear i and j to 0, set k=1, go to LEN.
  - LEN: ct_addr=0. Go to PT0.
  - PT0: len<=ct_dout; pt_addr=0; pt_din=ct_dout; pt_wren=1. If ct_dout==0, go to IDLE; otherwise go to RD_SI.
  - RD_SI: i<=i+1; s_addr=i+1. Go to RD_SJ.
  - RD_SJ: si<=s_dout; j<=j+s_dout; s_addr=j+s_dout. Go to WR_SI.
  - WR_SI: sj<=s_dout; s_addr=i; s_din=s_dout; s_wren=1. Go to WR_SJ.
  - WR_SJ: s_addr=j; s_din=si; s_wren=1. Go to RD_PAD.
  - RD_PAD: s_addr=si+sj; ct_addr=k. Go to XOR.
  - XOR: pt_addr=k; pt_din=s_dout^ct_dout; pt_wren=1. If k==len, go to IDLE; otherwise k<=k+1 and go to RD_SI.
- Arithmetic: all index sums are 8-bit modulo 256 (natural wrap). The k==len compare is made before any increment, so L=255 terminates correctly without k wrapping.
- Index corner case: when i==j, WR_SI and WR_SJ write the same value to the same address; this is the correct RC4 result.
- Latency: en accepted in cycle t, rdy high again in cycle t+3+6L. L=0 gives t+3.
- S RAM: the block leaves S in its post-swap state; it does not restore the KSA output.
- Reset mid-run: immediate return to IDLE with all write enables deasserted. Memory contents are partial and undefined; the next en restarts from i=j=0.
- Outputs: write enables are combinational from state only and never glitch-asserted outside the write states.

Decomposition:
- rc4_pkg:
  - state_t enum (IDLE, LEN, PT0, RD_SI, RD_SJ, WR_SI, WR_SJ, RD_PAD, XOR);
  - S_SIZE=256;
  - BYTE_W=8.
- No sub-module: a single FSM plus datapath registers.
- The top level muxes the S RAM port to rc4_prga in the new PRGA_WAIT/PRGA_RUNNING states, and connects the plaintext RAM to the debug port in DONE.

Test Plan:
- Identity S (S[n]=n), ct={0x01,0x00}, pulse en → pt[0]=0x01, pt[1]=0x02. S is unchanged (S[1]=1). rdy rises 9 cycles after the en cycle.
- Identity S, ct={0x02,0x00,0xFF} → pt[1]=0x02, pt[2]=0xFA (pad=S[5]=5). Afterwards S[2]=3, S[3]=2.
- ct[0]=0x00 → only pt[0]=0x00 written, no S writes, rdy back at t+3.
- Pulse en again 4 cycles into a run with L=3 → ignored: a single run, rdy returns at t+21, and pt is written exactly 4 times.
- Assert rst_n low during WR_SI → s_wren and pt_wren drop immediately; after release rdy=1. A new run on re-initialised identity S reproduces the first scenario's result.
- L=255, ct bytes all 0x00, compared against a software RC4 model on identity S → all 255 plaintext bytes match the model's keystream. k does not wrap, and the run ends in IDLE at t+1533.
